fp16_mul_seq: RTL and testbench

- Iterative half-precision (IEEE 754 binary16) multiplier, result = a * b; the inverse operation of the fp16 divider in the same arithmetic library.
- Uses a radix-2 shift-add mantissa multiplier over 11 cycles, with valid/ready handshakes on input and output.
- Fixed latency; truncating (no rounding); same special-case and denormal conventions as the library's other fp16 operators.
- Intended for area-constrained datapaths where a pipelined multiplier is too large.

---
 rtl/fp16_mul_seq.sv | 162 ++++++++++++++++
 tb/tb_fp16_mul_seq.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fp16_mul_seq.sv
// fp16_mul_seq: iterative binary16 multiplier, result = a * b.
// It uses a radix-2 shift-add mantissa multiply over 11 cycles, then one
// normalise/pack cycle. The latency is fixed and the result is truncated, not rounded.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready  operand handshake (in_ready = idle)
//   a, b                binary16 operands, sampled at the accepting edge
//   out_valid, out_ready result handshake; result held under backpressure
//   result              binary16 product, stable while out_valid
//   busy                high while an operation is in flight or waiting
module fp16_mul_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t state, state_nxt;

    logic               sign;
    logic [21:0]        mcand;
    logic [10:0]        mplier;
    logic [21:0]        acc;
    logic [3:0]         cnt;
    logic [4:0]         eff_a, eff_b;
    logic               spec_flag;
    logic [15:0]        spec_val;

    logic               spec_flag_d;
    logic [15:0]        spec_val_d;
    logic               sign_d;

    logic signed [6:0]  exp0, e, sh, rsh;
    logic [4:0]         lz;
    logic [10:0]        sig;
    logic [15:0]        norm_res;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = MUL;
            MUL:     if (cnt == 4'd0) state_nxt = NORM;
            NORM:    state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // Special-case operands are resolved at capture. The multiplier still runs
    // so that the latency does not depend on the operands.
    always_comb begin
        logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        a_nan  = (a[14:10] == 5'h1F) && (a[9:0] != 10'h0);
        b_nan  = (b[14:10] == 5'h1F) && (b[9:0] != 10'h0);
        a_inf  = (a[14:10] == 5'h1F) && (a[9:0] == 10'h0);
        b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'h0);
        a_zero = (a[14:0] == 15'h0);
        b_zero = (b[14:0] == 15'h0);
        sign_d = a[15] ^ b[15];
        spec_flag_d = 1'b1;
        spec_val_d  = 16'h0000;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            spec_val_d = 16'h7E00;
        else if (a_inf || b_inf)
            spec_val_d = {sign_d, 5'h1F, 10'h0};
        else if (a_zero || b_zero)
            spec_val_d = {sign_d, 15'h0};
        else
            spec_flag_d = 1'b0;
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign      <= 1'b0;
            mcand     <= 22'h0;
            mplier    <= 11'h0;
            acc       <= 22'h0;
            cnt       <= 4'd0;
            eff_a     <= 5'd0;
            eff_b     <= 5'd0;
            spec_flag <= 1'b0;
            spec_val  <= 16'h0;
            result    <= 16'h0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sign      <= sign_d;
                    mcand     <= {11'h0, (a[14:10] != 5'h0), a[9:0]};
                    mplier    <= {(b[14:10] != 5'h0), b[9:0]};
                    eff_a     <= (a[14:10] == 5'h0) ? 5'd1 : a[14:10];
                    eff_b     <= (b[14:10] == 5'h0) ? 5'd1 : b[14:10];
                    spec_flag <= spec_flag_d;
                    spec_val  <= spec_val_d;
                    acc       <= 22'h0;
                    cnt       <= 4'd10;
                end
                MUL: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - 4'd1;
                end
                NORM:    result <= spec_flag ? spec_val : norm_res;
                default: ;
            endcase
        end
    end

    // Normalise and pack. sig is the 11-bit significand {lead, frac} at
    // unbiased-plus-15 exponent e. A lead bit of 0 at e==1 is a denormal.
    always_comb begin
        exp0 = $signed({2'b00, eff_a}) + $signed({2'b00, eff_b}) - 7'sd15;
        lz = 5'd21;
        for (int i = 0; i <= 20; i++)
            if (acc[i]) lz = 5'(20 - i);
        sh  = 7'sd0;
        e   = exp0;
        sig = acc[20:10];
        if (acc[21]) begin
            sig = acc[21:11];
            e   = exp0 + 7'sd1;
        end else if (!acc[20] && (exp0 > 7'sd1)) begin
            // Denormal operand: normalise only as far as the exponent allows.
            sh  = ($signed({2'b00, lz}) < (exp0 - 7'sd1)) ? $signed({2'b00, lz})
                                                           : (exp0 - 7'sd1);
            sig = 11'((acc << sh) >> 10);
            e   = exp0 - sh;
        end
        rsh = 7'sd1 - e;
        if (e >= 7'sd31)
            norm_res = {sign, 5'h1F, 10'h0};
        else if (e <= 7'sd0) begin
            if (rsh >= 7'sd11) norm_res = {sign, 15'h0};
            else               norm_res = {sign, 5'h0, 10'(sig >> rsh[3:0])};
        end else
            norm_res = {sign, (sig[10] ? e[4:0] : 5'h0), sig[9:0]};
    end

endmodule

// File: tb/tb_fp16_mul_seq.sv
module tb_fp16_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        busy;

    int checks = 0;
    int errors = 0;

    fp16_mul_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait for out_valid after an accepting edge; returns the cycle count and
    // whether busy was high on every cycle before out_valid.
    task automatic wait_result(output int lat, output logic busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        while (!out_valid && lat < 40) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_op(input logic [15:0] av, input logic [15:0] bv,
                         input logic [15:0] exp_r, input string tag);
        int   lat;
        logic busy_ok;
        @(negedge clk);
        chk({tag, "_in_ready"}, 16'(in_ready), 16'd1);
        a = av; b = bv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'hFFFF; b = 16'hFFFF;   // must not affect the captured operands
        wait_result(lat, busy_ok);
        chk({tag, "_latency"}, 16'(lat), 16'd12);
        chk({tag, "_result"}, result, exp_r);
        chk({tag, "_busy"}, 16'(busy_ok), 16'd1);
        @(posedge clk); #1;
        chk({tag, "_drain"}, 16'(out_valid), 16'd0);
    endtask

    initial begin
        int   lat;
        logic busy_ok;
        logic stable_ok, ready_low_ok, ov_seen;
        logic [15:0] held;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = 16'h0; b = 16'h0;
        #2;
        chk("rst_in_ready", 16'(in_ready), 16'd1);
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_result", result, 16'h0000);
        @(negedge clk); rst_n = 1'b1;

        do_op(16'h3C00, 16'h3C00, 16'h3C00, "one_x_one");
        do_op(16'h4000, 16'h4200, 16'h4600, "two_x_three");
        do_op(16'hC000, 16'h4200, 16'hC600, "neg_two_x_three");
        do_op(16'h3E00, 16'h3E00, 16'h4080, "1p5_sq");
        do_op(16'h7BFF, 16'h7BFF, 16'h7C00, "overflow");
        do_op(16'h7C00, 16'h0000, 16'h7E00, "inf_x_zero");
        do_op(16'h7E01, 16'h3C00, 16'h7E00, "nan_in");
        do_op(16'hFC00, 16'h4000, 16'hFC00, "neg_inf");
        do_op(16'h8000, 16'h4000, 16'h8000, "neg_zero");
        do_op(16'h0001, 16'h4000, 16'h0002, "denorm_x2");
        do_op(16'h0200, 16'h3C00, 16'h0200, "denorm_x1");
        do_op(16'h0400, 16'h3400, 16'h0100, "minnorm_q");
        do_op(16'h0001, 16'h0001, 16'h0000, "underflow");

        // Backpressure
        out_ready = 1'b0;
        @(negedge clk);
        a = 16'h4000; b = 16'h4200; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result(lat, busy_ok);
        chk("bp_latency", 16'(lat), 16'd12);
        chk("bp_result", result, 16'h4600);
        held = result;
        stable_ok = 1'b1; ready_low_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 5) begin a = 16'h3C00; b = 16'h3C00; in_valid = 1'b1; end
            if (i == 8) in_valid = 1'b0;
            if (!out_valid || result !== held) stable_ok = 1'b0;
            if (in_ready) ready_low_ok = 1'b0;
        end
        chk("bp_stable", 16'(stable_ok), 16'd1);
        chk("bp_in_ready_low", 16'(ready_low_ok), 16'd1);
        chk("bp_result_after", result, 16'h4600);

        // Release with a new operand already waiting: one idle bubble
        @(negedge clk);
        out_ready = 1'b1;
        a = 16'h3E00; b = 16'h3E00; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("bubble_out_valid", 16'(out_valid), 16'd0);
        chk("bubble_in_ready", 16'(in_ready), 16'd1);
        @(posedge clk); #1;
        chk("bubble_accept", 16'(in_ready), 16'd0);
        in_valid = 1'b0;
        wait_result(lat, busy_ok);
        chk("bubble_latency", 16'(lat), 16'd12);
        chk("bubble_result", result, 16'h4080);
        @(posedge clk); #1;

        // Asynchronous reset during MUL cycle 5
        @(negedge clk);
        a = 16'h4000; b = 16'h4000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 16'(out_valid), 16'd0);
        chk("arst_in_ready", 16'(in_ready), 16'd1);
        chk("arst_result", result, 16'h0000);
        chk("arst_busy", 16'(busy), 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ov_seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (out_valid) ov_seen = 1'b1;
        end
        chk("arst_no_valid", 16'(ov_seen), 16'd0);
        do_op(16'h4200, 16'h4200, 16'h4880, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
